acc_arbiter: RTL and testbench
==============================

// Module: acc_arbiter
// PURPOSE
//  Owns the N_ACC shared 32-bit accumulators and arbitrates access to them from
//  N_CORE cores (parent is core 0, children are 1..N_CORE-1).
//  Each cycle it grants at most one request, round-robin, and applies one
//  fetch-and-op (read/add/write) to one accumulator.
//  It returns the pre-op value to the winner and drives acc_data to every core.
// PARAMETERS
//  N_CORE   4   number of requesting cores (>=1)
//  N_ACC    8   number of accumulators (>=2); AW = $clog2(N_ACC)
// PORTS
//  clk         in   1               single design clock
//  rst         in   1               asynchronous reset, active-high
//  clr         in   1               synchronous clear of all accumulators
//  req_valid   in   [N_CORE]        core i presents a request
//  req_acc     in   [N_CORE][AW]    target accumulator index
//  req_op      in   [N_CORE][2]     00 read, 01 add, 10 write, 11 reserved (= read)
//  req_data    in   [N_CORE][32]    operand for add/write
//  req_ready   out  [N_CORE]        one-hot grant; handshake completes when valid&ready
//  rsp_valid   out  [N_CORE]        one-hot; pulses 1 cycle after the handshake
//  rsp_data    out  32              pre-op value of the granted accumulator
//  acc_data    out  [N_ACC][32]     registered current value of every accumulator
// BEHAVIOUR
//  - Reset (async on rst rise, held while rst=1): all acc=0, rr_ptr=0,
//    rsp_valid=0, rsp_data=0; req_ready=0 while rst=1.
//  - Arbitration is combinational in the same cycle. Scan from rr_ptr upward,
//    wrapping modulo N_CORE; the first i with req_valid[i]=1 gets req_ready[i]=1.
//    Every other bit of req_ready is 0; req_ready is 0 when no core requests.
//  - req_ready never depends on req_acc, req_op or req_data of the winner.
//  - rr_ptr update: after a grant to core g, rr_ptr <= (g+1) mod N_CORE.
//    Without a grant, rr_ptr holds.
//  - Commit at the clock edge ending the handshake cycle. Let k=req_acc[g] and
//    old=acc[k]:
//      read : acc[k] unchanged
//      add  : acc[k] <= old + req_data[g], modulo 2^32 (no overflow flag, no saturation)
//      write: acc[k] <= req_data[g]
//  - Response: the next cycle has rsp_valid[g]=1 and rsp_data=old. rsp_valid is 0
//    otherwise; rsp_data holds its last value. Latency is 1 cycle.
//    Throughput is 1 op/cycle aggregate.
//  - A requester keeps req_valid and its fields stable until it sees req_ready.
//    It may deassert req_valid before a grant; no op is performed in that case.
//  - Back-to-back ops on the same acc: the second sees the first's result.
//    acc is registered and there is no forwarding hazard.
//  - acc_data[k] is the register output. It updates the cycle after commit,
//    together with rsp_valid.
//  - req_acc >= N_ACC (non-power-of-2 N_ACC): grant is given, the op is a no-op,
//    rsp_data=0.
//  - clr=1: all acc <= 0 at the edge and req_ready=0 that cycle (clr beats grants).
//    rr_ptr holds and no rsp_valid follows.
//  - rst mid-operation: the in-flight response is dropped (rsp_valid=0).
//    After rst falls, arbitration restarts at core 0.
//  - Fairness: with all N_CORE requesting continuously, each core is granted
//    exactly once every N_CORE cycles.
// TESTING
//  1. After reset, acc_data all 0. Core 0: add acc 3 by 5 -> ready same cycle.
//     Next cycle rsp_valid[0]=1, rsp_data=0, acc_data[3]=5.
//  2. All 4 cores request add 1 to acc 0 for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//     rsp_data=0..7 in order; final acc_data[0]=8.
//  3. Core 2 writes 0xFFFFFFFF to acc 1, then core 1 adds 2 to acc 1
//     -> second rsp_data=0xFFFFFFFF, acc_data[1]=1 (wrap).
//  4. Core 1 read on acc 5 while clr=1 -> no ready, no rsp. Next cycle, with
//     clr=0 -> ready[1]=1; rsp_data=0.
//  5. rst asserted the cycle after a handshake -> rsp_valid stays 0 and acc all 0.
//     After release the first grant goes to the lowest valid index.
//  6. Only core 3 requests, then only core 0 -> rr_ptr wraps 3->0, and both are
//     granted in consecutive cycles with no idle cycle.

Source files
------------

// File: rtl/acc_arbiter.sv
// Round-robin arbiter owning N_ACC shared 32-bit accumulators.
// Grants one core per cycle and applies one fetch-and-op, returning the pre-op value.

module acc_cell (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= wdata;
  end
endmodule

module acc_arbiter #(
  parameter int N_CORE = 4,
  parameter int N_ACC  = 8,
  localparam int AW = $clog2(N_ACC),
  localparam int CW = (N_CORE > 1) ? $clog2(N_CORE) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic [N_CORE-1:0]              req_valid,
  input  logic [N_CORE-1:0][AW-1:0]      req_acc,
  input  logic [N_CORE-1:0][1:0]         req_op,
  input  logic [N_CORE-1:0][31:0]        req_data,
  output logic [N_CORE-1:0]              req_ready,
  output logic [N_CORE-1:0]              rsp_valid,
  output logic [31:0]                    rsp_data,
  output logic [N_ACC-1:0][31:0]         acc_data
);
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;

  logic [CW-1:0]     rr_ptr, gidx, cand;
  logic [N_CORE-1:0] grant;
  logic              found, hs;
  int                idx;

  // Scan from rr_ptr upward; only valid bits steer the grant.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    if (!rst && !clr) begin
      for (int o = 0; o < N_CORE; o++) begin
        idx  = (int'(rr_ptr) + o) % N_CORE;
        cand = CW'(idx);
        if (!found && req_valid[cand]) begin
          found       = 1'b1;
          gidx        = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign hs        = found;

  logic [AW-1:0]    k;
  logic [1:0]       op;
  logic [31:0]      d, old, wdata;
  logic [N_ACC-1:0] we;

  assign k  = req_acc[gidx];
  assign op = req_op[gidx];
  assign d  = req_data[gidx];

  // Out-of-range indices match no accumulator, so old stays 0 and nothing is written.
  always_comb begin
    old = '0;
    we  = '0;
    for (int j = 0; j < N_ACC; j++) begin
      if (k == AW'(j)) begin
        old   = acc_data[j];
        we[j] = hs && (op == OP_ADD || op == OP_WR);
      end
    end
  end

  assign wdata = (op == OP_ADD) ? old + d : d;

  for (genvar j = 0; j < N_ACC; j++) begin : g_acc
    acc_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .we    (we[j]),
      .wdata (wdata),
      .q     (acc_data[j])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= grant;
      if (hs) begin
        rsp_data <= old;
        rr_ptr   <= (gidx == CW'(N_CORE - 1)) ? '0 : gidx + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_acc_arbiter.sv
// Randomized and directed checks of acc_arbiter against a queue-free reference model.

module tb_acc_arbiter;
  localparam int N_CORE = 4;
  localparam int N_ACC  = 8;
  localparam int AW     = 3;

  logic                      clk, rst, clr;
  logic [N_CORE-1:0]         req_valid;
  logic [N_CORE-1:0][AW-1:0] req_acc;
  logic [N_CORE-1:0][1:0]    req_op;
  logic [N_CORE-1:0][31:0]   req_data;
  logic [N_CORE-1:0]         req_ready, rsp_valid;
  logic [31:0]               rsp_data;
  logic [N_ACC-1:0][31:0]    acc_data;

  acc_arbiter #(.N_CORE(N_CORE), .N_ACC(N_ACC)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_acc(req_acc), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .acc_data(acc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] m_acc [N_ACC];
  int          m_rr;
  logic [31:0] m_rd;
  logic [N_CORE-1:0] m_rv;
  int          g_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant();
    if (rst || clr) return -1;
    for (int o = 0; o < N_CORE; o++) begin
      int i;
      i = (m_rr + o) % N_CORE;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_outs();
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    chk("rsp_data", 64'(rsp_data), 64'(m_rd));
    for (int j = 0; j < N_ACC; j++) chk($sformatf("acc%0d", j), 64'(acc_data[j]), 64'(m_acc[j]));
  endtask

  // One clock: inputs are already driven; check ready mid-cycle, then model the edge.
  task automatic step();
    int g;
    logic [N_CORE-1:0] eg;
    @(negedge clk);
    g  = exp_grant();
    eg = (g >= 0) ? N_CORE'(1) << g : '0;
    chk("req_ready", 64'(req_ready), 64'(eg));
    @(posedge clk);
    #1;
    m_rv = '0;
    if (clr) begin
      for (int j = 0; j < N_ACC; j++) m_acc[j] = '0;
    end else if (g >= 0) begin
      int kk;
      logic [31:0] o;
      kk = int'(req_acc[g]);
      o  = (kk < N_ACC) ? m_acc[kk] : 32'h0;
      if (kk < N_ACC) begin
        if (req_op[g] == 2'b01) m_acc[kk] = o + req_data[g];
        else if (req_op[g] == 2'b10) m_acc[kk] = req_data[g];
      end
      m_rv = eg;
      m_rd = o;
      m_rr = (g + 1) % N_CORE;
    end
    g_last = g;
    check_outs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int j = 0; j < N_ACC; j++) m_acc[j] = '0;
    m_rr = 0; m_rv = '0; m_rd = '0;
    check_outs();
    @(negedge clk);
    chk("ready_in_rst", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_acc = '0; req_op = '0; req_data = '0;
  endtask

  task automatic set_req(input int c, input int a, input logic [1:0] op, input logic [31:0] d);
    req_valid[c] = 1'b1;
    req_acc[c]   = AW'(a);
    req_op[c]    = op;
    req_data[c]  = d;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; g_last = -1;
    clear_reqs();
    do_reset();

    // 1: single add, one-cycle response
    set_req(0, 3, 2'b01, 32'd5);
    step();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_data", 64'(rsp_data), 64'h0);
    chk("t1_acc3", 64'(acc_data[3]), 64'd5);
    clear_reqs();
    step();

    // 2: all cores contend on acc 0
    do_reset();
    for (int c = 0; c < N_CORE; c++) set_req(c, 0, 2'b01, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_grant", 64'(rsp_valid), 64'(1) << (i % N_CORE));
      chk("t2_rsp_data", 64'(rsp_data), 64'(i));
    end
    chk("t2_acc0", 64'(acc_data[0]), 64'd8);
    clear_reqs();

    // 3: write then add wraps modulo 2^32
    set_req(2, 1, 2'b10, 32'hFFFF_FFFF);
    step();
    clear_reqs();
    set_req(1, 1, 2'b01, 32'd2);
    step();
    chk("t3_rsp_data", 64'(rsp_data), 64'hFFFF_FFFF);
    chk("t3_acc1", 64'(acc_data[1]), 64'd1);
    clear_reqs();

    // 4: clr blocks the grant
    clr = 1'b1;
    set_req(1, 5, 2'b00, 32'd0);
    step();
    chk("t4_no_rsp", 64'(rsp_valid), 64'h0);
    clr = 1'b0;
    step();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t4_rsp_data", 64'(rsp_data), 64'h0);
    clear_reqs();

    // 5: reset right after a handshake drops the response and restarts at core 0
    set_req(1, 2, 2'b01, 32'd7);
    step();
    clear_reqs();
    set_req(1, 4, 2'b00, 32'd0);
    set_req(3, 4, 2'b00, 32'd0);
    do_reset();
    chk("t5_acc2", 64'(acc_data[2]), 64'h0);
    step();
    chk("t5_first_grant", 64'(rsp_valid), 64'h2);
    clear_reqs();

    // 6: pointer wraps 3 -> 0 with no idle cycle
    set_req(3, 6, 2'b01, 32'd3);
    step();
    chk("t6_core3", 64'(rsp_valid), 64'h8);
    clear_reqs();
    set_req(0, 6, 2'b01, 32'd4);
    step();
    chk("t6_core0", 64'(rsp_valid), 64'h1);
    chk("t6_rsp_data", 64'(rsp_data), 64'd3);
    clear_reqs();

    // Random traffic; pending requests stay stable unless withdrawn.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
        g_last = -1;
      end
      clr = ($urandom_range(15) == 0);
      for (int c = 0; c < N_CORE; c++) begin
        if (req_valid[c] && c != g_last) begin
          if ($urandom_range(7) == 0) req_valid[c] = 1'b0;
        end else begin
          req_valid[c] = ($urandom_range(1) == 1);
          req_acc[c]   = AW'($urandom_range(N_ACC - 1));
          req_op[c]    = 2'($urandom_range(3));
          req_data[c]  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                                  : 32'($urandom);
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
